// File: rtl/hog_feature_streamer.sv
// HOG feature streamer: reads fixed-point HOG bins from NBANK parallel result RAMs,
// converts each value to IEEE-754 single precision, packs R reads into one
// AXI-Stream beat and streams NBIN*BEATS_PER_BIN beats per frame.
module hog_feature_streamer #(
    parameter int RAM_AW        = 17,
    parameter int QN            = 10,
    parameter int NBANK         = 4,
    parameter int AXI_DW        = 512,
    parameter int NBIN          = 31,
    parameter int BEATS_PER_BIN = 64,
    parameter int G1            = 18,
    parameter int G2            = 27,
    parameter int FB0           = 0,
    parameter int FB1           = 1,
    parameter int FB2           = 3
) (
    input  logic                  aclk,
    input  logic                  arest,
    input  logic                  start,
    input  logic                  test_mode,
    output logic                  ram_en,
    output logic [RAM_AW-1:0]     ram_addr,
    input  logic [NBANK*QN-1:0]   ram_dout,
    output logic [AXI_DW-1:0]     m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  busy,
    output logic                  done
);

    localparam int R     = AXI_DW / (32 * NBANK);
    localparam int WORD  = 32 * NBANK;
    localparam int NBEAT = NBIN * BEATS_PER_BIN;
    localparam int W     = NBEAT * R;
    localparam int RCW   = $clog2(R + 1);
    localparam int BTW   = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int BNW   = (NBIN > 1) ? $clog2(NBIN) : 1;
    localparam int BBW   = (BEATS_PER_BIN > 1) ? $clog2(BEATS_PER_BIN) : 1;

    localparam logic [RCW-1:0]    RD_LAST   = RCW'(R);
    localparam logic [RAM_AW-1:0] ADDR_LAST = RAM_AW'(W - 1);
    localparam logic [BTW-1:0]    BEAT_LAST = BTW'(NBEAT - 1);
    localparam logic [BNW-1:0]    BIN_LAST  = BNW'(NBIN - 1);
    localparam logic [BBW-1:0]    BIB_LAST  = BBW'(BEATS_PER_BIN - 1);
    localparam logic [BNW-1:0]    G1_B      = BNW'(G1);
    localparam logic [BNW-1:0]    G2_B      = BNW'(G2);

    typedef enum logic [1:0] {StIdle, StRead, StOut, StDone} state_t;

    state_t              state_q, state_d;
    logic [RCW-1:0]      rd_cnt_q;
    logic [RAM_AW-1:0]   addr_q;
    logic [BTW-1:0]      beat_q;
    logic [BNW-1:0]      bin_q;
    logic [BBW-1:0]      bib_q;
    logic [AXI_DW-1:0]   tdata_q;
    logic [WORD-1:0]     word;
    int unsigned         fb;
    logic                last_read_done;
    logic                last_beat;
    logic                handshake;

    // Unsigned QN-bit fraction to float: exponent from leading-one position,
    // remaining bits left-aligned into the mantissa (exact for QN <= 24).
    function automatic logic [31:0] to_float(input logic [QN-1:0] v);
        logic [23:0] norm;
        logic [7:0]  expo;
        int          p;
        p = 0;
        for (int i = 0; i < QN; i++) begin
            if (v[i]) p = i;
        end
        norm = 24'(v) << (23 - p);
        expo = 8'(127 - QN + p);
        if (v == '0) return 32'h0;
        return {1'b0, expo, norm[22:0]};
    endfunction

    assign last_read_done = (state_q == StRead) && (rd_cnt_q == RD_LAST);
    assign last_beat      = (beat_q == BEAT_LAST);
    assign handshake      = (state_q == StOut) && m_tready;

    // FSM state register.
    always_ff @(posedge aclk or posedge arest) begin
        if (arest) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // FSM next-state logic; start is only honoured in idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRead;
            StRead:  if (last_read_done) state_d = StOut;
            StOut:   if (m_tready) state_d = last_beat ? StDone : StRead;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        ram_en   = (state_q == StRead) && (rd_cnt_q < RD_LAST);
        m_tvalid = (state_q == StOut);
        m_tlast  = (state_q == StOut) && last_beat;
        busy     = (state_q == StRead) || (state_q == StOut);
        done     = (state_q == StDone);
    end

    // Read-cycle counter: 0..R-1 issue reads, R captures the final word.
    always_ff @(posedge aclk or posedge arest) begin
        if (arest)                                    rd_cnt_q <= '0;
        else if (state_q == StRead && !last_read_done) rd_cnt_q <= rd_cnt_q + RCW'(1);
        else                                          rd_cnt_q <= '0;
    end

    // Read address; wraps at the frame size so each frame starts at 0.
    always_ff @(posedge aclk or posedge arest) begin
        if (arest)       addr_q <= '0;
        else if (ram_en) addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + RAM_AW'(1);
    end

    // Beat, beat-in-bin and bin counters advance on each accepted beat.
    always_ff @(posedge aclk or posedge arest) begin
        if (arest) begin
            beat_q <= '0;
            bib_q  <= '0;
            bin_q  <= '0;
        end else if (handshake) begin
            beat_q <= last_beat ? '0 : beat_q + BTW'(1);
            if (bib_q == BIB_LAST) begin
                bib_q <= '0;
                bin_q <= (bin_q == BIN_LAST) ? '0 : bin_q + BNW'(1);
            end else begin
                bib_q <= bib_q + BBW'(1);
            end
        end
    end

    // First-bank offset selected by bin group.
    always_comb begin
        if (bin_q < G1_B)      fb = int'(FB0);
        else if (bin_q < G2_B) fb = int'(FB1);
        else                   fb = int'(FB2);
    end

    // Rotate banks into lanes and convert each to float.
    always_comb begin
        word = '0;
        for (int j = 0; j < NBANK; j++) begin
            word[j*32 +: 32] = to_float(ram_dout[((fb + j) % NBANK)*QN +: QN]);
        end
    end

    // Pack the word returned for read (rd_cnt-1); test_mode overrides the whole beat.
    always_ff @(posedge aclk or posedge arest) begin
        if (arest) begin
            tdata_q <= '0;
        end else if (state_q == StRead && rd_cnt_q != '0) begin
            if (last_read_done && test_mode)
                tdata_q <= '1;
            else
                tdata_q[(int'(rd_cnt_q) - 1)*WORD +: WORD] <= word;
        end
    end

    assign ram_addr = addr_q;
    assign m_tdata  = tdata_q;

endmodule

// File: tb/tb_hog_feature_streamer.sv
// Bench for hog_feature_streamer: RAM model, beat monitor, reference model using
// real-number float conversion, table vectors and hand-written corner sequences.
module tb_hog_feature_streamer;

    localparam int RAM_AW = 17, QN = 10, NBANK = 4, AXI_DW = 512;
    localparam int NBIN = 31, BPB = 64, G1 = 18, G2 = 27, FB0 = 0, FB1 = 1, FB2 = 3;
    localparam int R = AXI_DW / (32 * NBANK);
    localparam int NBEAT = NBIN * BPB;
    localparam int W = NBEAT * R;

    logic                 aclk = 1'b0;
    logic                 arest, start, test_mode, ram_en, m_tvalid, m_tready, m_tlast;
    logic                 busy, done;
    logic [RAM_AW-1:0]    ram_addr;
    logic [NBANK*QN-1:0]  ram_dout;
    logic [AXI_DW-1:0]    m_tdata;

    logic [QN-1:0]        mem [NBANK][W];
    logic [AXI_DW-1:0]    got_data[$];
    logic                 got_last[$];
    int                   exp_addr = 0, addr_errs = 0, done_cnt = 0;
    int                   checks = 0, errors = 0;

    typedef struct {
        logic [QN-1:0] v;
        logic [31:0]   f;
    } conv_vec_t;

    hog_feature_streamer dut (
        .aclk     (aclk),
        .arest    (arest),
        .start    (start),
        .test_mode(test_mode),
        .ram_en   (ram_en),
        .ram_addr (ram_addr),
        .ram_dout (ram_dout),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .busy     (busy),
        .done     (done)
    );

    always #5 aclk = ~aclk;

    // Result RAM model, one-cycle read latency.
    always @(posedge aclk) begin
        if (ram_en) begin
            for (int k = 0; k < NBANK; k++)
                ram_dout[k*QN +: QN] <= (int'(ram_addr) < W) ? mem[k][ram_addr] : '0;
        end
    end

    // Monitor on the falling edge: address sequence, accepted beats, done pulses.
    initial begin
        forever begin
            @(negedge aclk);
            if (arest) begin
                exp_addr = 0;
            end else begin
                if (ram_en) begin
                    if (int'(ram_addr) != exp_addr) addr_errs++;
                    exp_addr = (exp_addr + 1) % W;
                end
                if (m_tvalid && m_tready) begin
                    got_data.push_back(m_tdata);
                    got_last.push_back(m_tlast);
                end
                if (done) done_cnt++;
            end
        end
    end

    task automatic chk(input string name, input logic [AXI_DW-1:0] act, input logic [AXI_DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference conversion through the real-number domain.
    function automatic logic [31:0] ref_float(input int v);
        real         r;
        logic [63:0] b;
        if (v == 0) return 32'h0;
        r = v / (2.0 ** QN);
        b = $realtobits(r);
        return {1'b0, 8'(int'(b[62:52]) - 1023 + 127), b[51:29]};
    endfunction

    function automatic logic [AXI_DW-1:0] exp_beat(input int b, input bit tm);
        logic [AXI_DW-1:0] d;
        int bin, fb;
        if (tm) return '1;
        bin = b / BPB;
        fb  = (bin < G1) ? FB0 : (bin < G2) ? FB1 : FB2;
        d = '0;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < NBANK; j++)
                d[i*32*NBANK + j*32 +: 32] = ref_float(int'(mem[(fb + j) % NBANK][b*R + i]));
        return d;
    endfunction

    task automatic fill_default();
        for (int k = 0; k < NBANK; k++)
            for (int a = 0; a < W; a++) mem[k][a] = QN'((a + k) % 1024);
    endtask

    task automatic fill_random();
        for (int k = 0; k < NBANK; k++)
            for (int a = 0; a < W; a++)
                mem[k][a] = ($urandom_range(0, 7) == 0) ? '0 : QN'($urandom_range(0, 1023));
    endtask

    task automatic check_frame(input string tag, input bit tm);
        int bad_d = 0, bad_l = 0, first = -1;
        chk({tag, " beat count"}, got_data.size(), NBEAT);
        for (int b = 0; b < got_data.size() && b < NBEAT; b++) begin
            if (got_data[b] !== exp_beat(b, tm)) begin
                bad_d++;
                if (first < 0) first = b;
            end
            if (got_last[b] !== (b == NBEAT - 1)) bad_l++;
        end
        if (first >= 0) $display("  %s first bad beat %0d", tag, first);
        chk({tag, " data beats wrong"}, bad_d, 0);
        chk({tag, " tlast beats wrong"}, bad_l, 0);
        chk({tag, " address errors"}, addr_errs, 0);
        chk({tag, " done pulses"}, done_cnt, 1);
    endtask

    // mode 0: ready always 1, start held high all frame (incl. the done cycle).
    // mode 1: random ready, single start pulse, one 5-cycle stall near beat 100.
    task automatic run_frame(input int mode, input string tag);
        int cycles = 0, quiet_bad = 0;
        bit seen = 0, stalled = 0, ok;
        logic [AXI_DW-1:0] d;
        logic l;
        got_data.delete();
        got_last.delete();
        done_cnt  = 0;
        addr_errs = 0;
        m_tready  = (mode == 0);
        start     = 1'b1;
        @(posedge aclk); #1;
        if (mode != 0) start = 1'b0;
        chk({tag, " busy after start"}, busy, 1);
        while (!seen && cycles < 40000) begin
            if (mode != 0) begin
                m_tready = 1'($urandom_range(0, 1));
                if (!stalled && got_data.size() >= 100 && m_tvalid) begin
                    d = m_tdata;
                    l = m_tlast;
                    m_tready = 1'b0;
                    ok = 1;
                    repeat (5) begin
                        @(posedge aclk); #1;
                        cycles++;
                        if (m_tdata !== d || m_tvalid !== 1'b1 || m_tlast !== l || ram_en !== 1'b0)
                            ok = 0;
                    end
                    stalled = 1;
                    chk({tag, " stall hold"}, ok, 1);
                end
            end
            @(posedge aclk); #1;
            cycles++;
            if (done) seen = 1;
        end
        start = 1'b0;
        chk({tag, " done seen"}, seen, 1);
        repeat (3) begin
            @(posedge aclk); #1;
            if (busy || done || ram_en || m_tvalid) quiet_bad++;
        end
        chk({tag, " idle after done"}, quiet_bad, 0);
    endtask

    initial begin
        conv_vec_t tbl[8];
        int cycles;
        tbl[0] = '{10'h200, 32'h3F000000};
        tbl[1] = '{10'h001, 32'h3A800000};
        tbl[2] = '{10'h3FF, 32'h3F7FC000};
        tbl[3] = '{10'h000, 32'h00000000};
        tbl[4] = '{10'h100, 32'h3E800000};
        tbl[5] = '{10'h300, 32'h3F400000};
        tbl[6] = '{10'h002, 32'h3B000000};
        tbl[7] = '{10'h180, 32'h3EC00000};

        arest = 1'b1; start = 1'b0; test_mode = 1'b0; m_tready = 1'b0;
        fill_default();
        #1;
        chk("reset tdata", m_tdata, 0);
        chk("reset ctrl", {ram_en, ram_addr, m_tvalid, m_tlast, busy, done}, 0);
        @(posedge aclk); #1;
        arest = 1'b0;
        @(posedge aclk); #1;

        // Frame 1: default pattern, start held high throughout.
        run_frame(0, "f1");
        check_frame("f1", 0);

        // Frame 2: random data, conversion table and group-boundary vectors.
        fill_random();
        for (int i = 0; i < 8; i++) mem[i / 4][i % 4] = tbl[i].v;
        for (int k = 0; k < NBANK; k++) begin
            mem[k][G1*BPB*R] = QN'(k + 1);
            mem[k][G2*BPB*R] = QN'(k + 1);
        end
        run_frame(1, "f2");
        check_frame("f2", 0);
        for (int i = 0; i < 8; i++) begin
            if (got_data.size() > 0)
                chk($sformatf("conv %h", tbl[i].v), got_data[0][(i % 4)*128 + (i / 4)*32 +: 32], tbl[i].f);
            else
                chk("conv no beat", 0, 1);
        end
        if (got_data.size() > G2 * BPB) begin
            chk("bin18 lanes", got_data[G1*BPB][127:0], 128'h3A800000_3B800000_3B400000_3B000000);
            chk("bin27 lanes", got_data[G2*BPB][127:0], 128'h3B400000_3B000000_3A800000_3B800000);
        end else begin
            chk("group beats present", got_data.size(), NBEAT);
        end

        // Reset at beat 700, then a fresh full frame.
        got_data.delete(); got_last.delete();
        done_cnt = 0;
        m_tready = 1'b1;
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        cycles = 0;
        while (got_data.size() < 700 && cycles < 20000) begin
            @(posedge aclk); #1;
            cycles++;
        end
        chk("reached beat 700", got_data.size() >= 700, 1);
        arest = 1'b1;
        #1;
        chk("midreset tdata", m_tdata, 0);
        chk("midreset ctrl", {ram_en, ram_addr, m_tvalid, m_tlast, busy, done}, 0);
        repeat (2) @(posedge aclk);
        #1;
        arest = 1'b0;
        @(posedge aclk); #1;
        chk("no done on abandon", done_cnt, 0);
        fill_random();
        run_frame(1, "f3");
        check_frame("f3", 0);

        // Frame 4: test mode, every beat all-ones.
        test_mode = 1'b1;
        run_frame(0, "f4");
        check_frame("f4", 1);
        test_mode = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
